mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_pick.sv | 20 ++
 rtl/mem_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory read arbiter (mem_arbiter).
// The round-robin build is selected with MEM_ARB_RR_EN.
package mem_arb_pkg;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_idx_e;

    // Response owed to a requester in the cycle after its grant.
    typedef struct packed {
        logic     valid;
        req_idx_e owner;
        logic     err;
    } rsp_t;

    localparam int unsigned DEFAULT_MEM_WORDS = 256;

    // The byte offset within a word never affects the range decision.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned words);
        return ({2'b00, addr[31:2]} < words);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: a lone requester always wins, and on a
// conflict the requester that did not win most recently takes the grant.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic     if_req,
    input  logic     d_req,
    input  req_idx_e last_winner,
    output logic [1:0] win_oh
);

    // win_oh[0] = fetch port, win_oh[1] = data port.
    always_comb begin
        win_oh = {d_req, if_req};
        if (if_req && d_req) begin
            win_oh = (last_winner == REQ_D) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/load) read arbiter in front of a 1-cycle-latency memory.
// Define MEM_ARB_RR_EN for round-robin; otherwise the data port has priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic        mem_r_enable,
    input  logic [31:0] mem_rdata
);

    logic        if_req_ok;
    logic        d_req_ok;
    logic [1:0]  win_oh;
    req_idx_e    last_winner;
    logic        grant;
    req_idx_e    win_idx;
    logic [31:0] win_addr;
    logic        win_in_range;
    rsp_t        rsp_q;
    rsp_t        rsp_d;
    logic        rsp_live;

    // No grant may be issued while reset is held.
    assign if_req_ok = if_req & ~rst;
    assign d_req_ok  = d_req & ~rst;

`ifdef MEM_ARB_RR_EN
    req_idx_e last_winner_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner_q <= REQ_D;
        end else if (grant) begin
            last_winner_q <= win_idx;
        end
    end

    assign last_winner = last_winner_q;
`else
    // Pinning the "previous winner" to fetch turns the picker into data-port priority.
    assign last_winner = REQ_IF;
`endif

    mem_arb_pick u_pick (
        .if_req      (if_req_ok),
        .d_req       (d_req_ok),
        .last_winner (last_winner),
        .win_oh      (win_oh)
    );

    always_comb begin
        grant        = |win_oh;
        win_idx      = win_oh[1] ? REQ_D : REQ_IF;
        win_addr     = win_oh[1] ? d_addr : if_addr;
        win_in_range = addr_in_range(win_addr, MEM_WORDS);
    end

    // Response state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q <= '0;
        end else begin
            rsp_q <= rsp_d;
        end
    end

    // Next response: loaded on every grant, otherwise nothing is pending.
    always_comb begin
        rsp_d       = '0;
        rsp_d.owner = rsp_q.owner;
        if (grant) begin
            rsp_d.valid = 1'b1;
            rsp_d.owner = win_idx;
            rsp_d.err   = ~win_in_range;
        end
    end

    // Request-side and response-side outputs.
    always_comb begin
        if_gnt       = win_oh[0];
        d_gnt        = win_oh[1];
        mem_addr     = grant ? win_addr : 32'h0;
        mem_r_enable = grant & win_in_range;

        // A response still pending when reset arrives is dropped, not delivered.
        rsp_live  = rsp_q.valid & ~rst;
        if_rvalid = rsp_live & (rsp_q.owner == REQ_IF);
        d_rvalid  = rsp_live & (rsp_q.owner == REQ_D);
        if_err    = if_rvalid & rsp_q.err;
        d_err     = d_rvalid & rsp_q.err;
        if_rdata  = (if_rvalid && !rsp_q.err) ? mem_rdata : 32'h0;
        d_rdata   = (d_rvalid && !rsp_q.err) ? mem_rdata : 32'h0;
    end

endmodule
